// File: rtl/mojo_sdram_top.sv
// Mojo SDRAM shield top: controller plus a write-then-readback memory test, results on led.
// Commands reach the pins one cycle after the FSM decides; no backpressure, the sequencer free-runs until reset.
module mojo_sdram_top #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int INIT_CYCLES    = 20000,
    parameter int REFRESH_CYCLES = 750,
    parameter int CAS_LATENCY    = 2,
    parameter int TEST_WORDS     = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cclk,
    output logic [7:0]  led,
    output logic        spi_miso,
    input  logic        spi_ss,
    input  logic        spi_mosi,
    input  logic        spi_sck,
    output logic [3:0]  spi_channel,
    input  logic        avr_tx,
    output logic        avr_rx,
    input  logic        avr_rx_busy,
    output logic        sdram_clk,
    output logic        sdram_cle,
    output logic        sdram_dqm,
    output logic        sdram_cs,
    output logic        sdram_ras,
    output logic        sdram_cas,
    output logic        sdram_we,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_a,
    inout  wire  [7:0]  sdram_dq
);
    localparam logic [3:0]  CMD_NOP = 4'b0111;
    localparam logic [3:0]  CMD_PRE = 4'b0010;
    localparam logic [3:0]  CMD_REF = 4'b0001;
    localparam logic [3:0]  CMD_MRS = 4'b0000;
    localparam logic [3:0]  CMD_ACT = 4'b0011;
    localparam logic [3:0]  CMD_RD  = 4'b0101;
    localparam logic [3:0]  CMD_WR  = 4'b0100;
    localparam logic [15:0] T_RP    = 16'd2;
    localparam logic [15:0] T_RFC   = 16'd7;
    localparam logic [15:0] T_MRD   = 16'd2;
    localparam logic [15:0] T_RCD   = 16'd2;
    localparam logic [15:0] T_WR    = 16'd4;
    localparam logic [15:0] T_RD    = 16'(CAS_LATENCY + 2);
    localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
    localparam logic [15:0] REF_DUE   = 16'(REFRESH_CYCLES);
    localparam logic [9:0]  LAST_WORD = 10'(TEST_WORDS - 1);
    localparam logic [12:0] MODE = {3'b000, 1'b1, 2'b00, 3'(CAS_LATENCY), 1'b0, 3'b000};

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
        S_ACT, S_ACCESS, S_REFRESH, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic        rst;
    logic [15:0] cnt, cnt_nxt, ref_cnt;
    logic [9:0]  word, word_nxt;
    logic        rd_phase, rd_phase_nxt;
    logic        init_done, wr_done, rd_done, fail;
    logic        set_init, set_wr_done, set_rd_done, ref_clr, ref_due, rd_sample;
    logic [3:0]  cmd_nxt, cmd_q;
    logic [12:0] a_nxt, a_q;
    logic [7:0]  dq_nxt, dq_q;
    logic        oe_nxt, dq_oe, cle_q, dqm_q;
    logic [1:0]  ba_q;
    logic        unused_ok;

    assign rst       = ~rst_n;
    assign ref_due   = (ref_cnt == REF_DUE);
    // READ left the pins CAS_LATENCY+1 edges ago; its data is on the bus at this edge
    assign rd_sample = (state == S_ACCESS) && rd_phase && (cnt == T_RD - 16'd1);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + 16'd1;
        word_nxt     = word;
        rd_phase_nxt = rd_phase;
        cmd_nxt      = CMD_NOP;
        a_nxt        = '0;
        dq_nxt       = '0;
        oe_nxt       = 1'b0;
        set_init     = 1'b0;
        set_wr_done  = 1'b0;
        set_rd_done  = 1'b0;
        ref_clr      = 1'b0;
        case (state)
            S_INIT_WAIT: if (cnt == INIT_LAST) begin state_nxt = S_INIT_PRE; cnt_nxt = '0; end
            S_INIT_PRE: begin
                if (cnt == 16'd0) begin cmd_nxt = CMD_PRE; a_nxt[10] = 1'b1; end
                if (cnt == T_RP) begin state_nxt = S_INIT_REF1; cnt_nxt = '0; end
            end
            S_INIT_REF1, S_INIT_REF2: begin
                if (cnt == 16'd0) cmd_nxt = CMD_REF;
                if (cnt == T_RFC) begin
                    state_nxt = (state == S_INIT_REF1) ? S_INIT_REF2 : S_INIT_MRS;
                    cnt_nxt   = '0;
                end
            end
            S_INIT_MRS: begin
                if (cnt == 16'd0) begin cmd_nxt = CMD_MRS; a_nxt = MODE; end
                if (cnt == T_MRD) begin set_init = 1'b1; state_nxt = S_ACT; cnt_nxt = '0; end
            end
            S_ACT: begin
                if (cnt == 16'd0) cmd_nxt = CMD_ACT;
                if (cnt == T_RCD) begin state_nxt = S_ACCESS; cnt_nxt = '0; end
            end
            S_ACCESS: begin
                if (cnt == 16'd0) begin
                    cmd_nxt = rd_phase ? CMD_RD : CMD_WR;
                    a_nxt   = {2'b00, 1'b1, word};
                    dq_nxt  = word[7:0];
                    oe_nxt  = ~rd_phase;
                end
                // refresh is only slotted in here, between complete accesses
                if (cnt == (rd_phase ? T_RD : T_WR)) begin
                    cnt_nxt   = '0;
                    state_nxt = ref_due ? S_REFRESH : S_ACT;
                    if (word != LAST_WORD) begin
                        word_nxt = word + 10'd1;
                    end else if (rd_phase) begin
                        set_rd_done = 1'b1;
                        state_nxt   = S_DONE;
                    end else begin
                        set_wr_done  = 1'b1;
                        rd_phase_nxt = 1'b1;
                        word_nxt     = '0;
                    end
                end
            end
            S_REFRESH: begin
                if (cnt == 16'd0) begin cmd_nxt = CMD_REF; ref_clr = 1'b1; end
                if (cnt == T_RFC) begin state_nxt = rd_done ? S_DONE : S_ACT; cnt_nxt = '0; end
            end
            S_DONE: if (ref_due) begin state_nxt = S_REFRESH; cnt_nxt = '0; end
            default: begin state_nxt = S_INIT_WAIT; cnt_nxt = '0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT_WAIT;
            cnt       <= '0;
            word      <= '0;
            rd_phase  <= 1'b0;
            init_done <= 1'b0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            fail      <= 1'b0;
            ref_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            word     <= word_nxt;
            rd_phase <= rd_phase_nxt;
            if (set_init)    init_done <= 1'b1;
            if (set_wr_done) wr_done   <= 1'b1;
            if (set_rd_done) rd_done   <= 1'b1;
            // equality-else form so unknown bus values also count as a miscompare
            if (rd_sample) begin
                if (sdram_dq == word[7:0]) fail <= fail;
                else                       fail <= 1'b1;
            end
            if (ref_clr)                    ref_cnt <= '0;
            else if (init_done && !ref_due) ref_cnt <= ref_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cle_q <= 1'b0;
            cmd_q <= 4'b1111;
            dqm_q <= 1'b1;
            ba_q  <= 2'b00;
            a_q   <= '0;
            dq_q  <= '0;
            dq_oe <= 1'b0;
        end else begin
            cle_q <= 1'b1;
            cmd_q <= cmd_nxt;
            if (set_init) dqm_q <= 1'b0;
            ba_q  <= 2'b00;
            a_q   <= a_nxt;
            dq_q  <= dq_nxt;
            dq_oe <= oe_nxt;
        end
    end

    assign sdram_clk = ~clk;
    assign sdram_cle = cle_q;
    assign sdram_dqm = dqm_q;
    assign {sdram_cs, sdram_ras, sdram_cas, sdram_we} = cmd_q;
    assign sdram_ba  = ba_q;
    assign sdram_a   = a_q;
    assign sdram_dq  = dq_oe ? dq_q : 8'bz;

    assign led = {3'b000, fail, rd_done & ~fail, rd_done, wr_done, init_done};

    assign spi_miso    = 1'bz;
    assign spi_channel = 4'bzzzz;
    assign avr_rx      = 1'bz;
    assign unused_ok   = &{1'b0, cclk, spi_ss, spi_mosi, spi_sck, avr_tx, avr_rx_busy, (CLK_HZ != 0)};
endmodule

// File: tb/tb_mojo_sdram_top.sv
// Bench for mojo_sdram_top: behavioural SDRAM model, expected-command scoreboard, LED result checks.
module tb_mojo_sdram_top;
    localparam int INIT_CYC = 100;
    localparam int REF_CYC  = 20;
    localparam int CL       = 2;
    localparam int TW       = 64;

    localparam logic [3:0] C_NOP = 4'b0111, C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;
    localparam logic [3:0] C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR  = 4'b0100;
    // write-burst single, CL=2, sequential, burst length 1
    localparam logic [12:0] MODE_A = {3'b000, 1'b1, 2'b00, 3'd2, 1'b0, 3'b000};

    typedef struct packed {
        logic [3:0]  cmd;
        logic [12:0] a;
        logic [7:0]  d;
        logic        wr;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cclk = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b0, spi_sck = 1'b0, avr_tx = 1'b1, avr_rx_busy = 1'b0;
    logic [7:0] led;
    wire spi_miso, avr_rx;
    wire [3:0] spi_channel;
    logic sdram_clk, sdram_cle, sdram_dqm, sdram_cs, sdram_ras, sdram_cas, sdram_we;
    logic [1:0] sdram_ba;
    logic [12:0] sdram_a;
    wire [7:0] sdram_dq;
    logic model_oe = 1'b0;
    logic [7:0] model_dat = 8'h00;

    assign sdram_dq = model_oe ? model_dat : 8'bz;

    mojo_sdram_top #(.INIT_CYCLES(INIT_CYC), .REFRESH_CYCLES(REF_CYC), .CAS_LATENCY(CL), .TEST_WORDS(TW)) dut (
        .clk(clk), .rst_n(rst_n), .cclk(cclk), .led(led),
        .spi_miso(spi_miso), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_sck(spi_sck),
        .spi_channel(spi_channel), .avr_tx(avr_tx), .avr_rx(avr_rx), .avr_rx_busy(avr_rx_busy),
        .sdram_clk(sdram_clk), .sdram_cle(sdram_cle), .sdram_dqm(sdram_dqm),
        .sdram_cs(sdram_cs), .sdram_ras(sdram_ras), .sdram_cas(sdram_cas), .sdram_we(sdram_we),
        .sdram_ba(sdram_ba), .sdram_a(sdram_a), .sdram_dq(sdram_dq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    logic [7:0] mem [0:1023];
    logic       corrupt = 1'b0;
    int         bad_addr = 0;
    logic [7:0] bad_mask = 8'h00;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    function automatic void chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endfunction

    function automatic int min_gap(input logic [3:0] c);
        case (c)
            C_PRE:   return 2;
            C_REF:   return 7;
            C_MRS:   return 2;
            C_ACT:   return 2;
            C_WR:    return 4;
            C_RD:    return CL + 2;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t mk(input logic [3:0] c, input logic [12:0] a, input logic [7:0] d, input logic wr);
        exp_t e;
        e.cmd = c; e.a = a; e.d = d; e.wr = wr;
        return e;
    endfunction

    // Monitor + SDRAM model: observes the pins mid-cycle, pops expected commands, serves reads after CL.
    int         nop_run, since_ref, done_refs;
    logic [3:0] last_cmd;
    logic       started, mrs_seen, row_open, act_seen, rd_seen;
    logic       pv [CL];
    logic [7:0] pd [CL];

    always @(negedge clk) begin
        logic [3:0] c;
        exp_t e;
        if (!rst_n) begin
            started = 1'b0; mrs_seen = 1'b0; row_open = 1'b0; act_seen = 1'b0; rd_seen = 1'b0;
            nop_run = 0; since_ref = 0; done_refs = 0; last_cmd = C_NOP; model_oe = 1'b0;
            for (int j = 0; j < CL; j++) pv[j] = 1'b0;
        end else begin
            model_oe  = pv[CL-1];
            model_dat = pd[CL-1];
            for (int j = CL - 1; j > 0; j--) begin pv[j] = pv[j-1]; pd[j] = pd[j-1]; end
            pv[0] = 1'b0;
            since_ref++;
            c = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
            if (c == C_NOP) begin
                nop_run++;
            end else begin
                chk("cle_high", sdram_cle, 1'b1);
                if (!started) chk("init_nop_count", nop_run, INIT_CYC);
                else chk_range("cmd_gap", nop_run, min_gap(last_cmd), 100000);
                if (c == C_REF && mrs_seen) begin
                    chk("ref_outside_access", row_open, 1'b0);
                    chk_range("ref_interval", since_ref, 1, REF_CYC + 14);
                    since_ref = 0;
                    if (led[2]) done_refs++;
                end else if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd: got %b, required no further command", c);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd", c, e.cmd);
                    chk("addr", {sdram_ba, sdram_a}, {2'b00, e.a});
                    if (e.wr) chk("wdata", sdram_dq, e.d);
                end
                if (c == C_MRS) begin mrs_seen = 1'b1; since_ref = 0; end
                if (c == C_ACT) begin
                    if (!act_seen) chk("led_at_first_act", led, 8'h01);
                    act_seen = 1'b1;
                    row_open = 1'b1;
                end
                if (c == C_WR) begin
                    mem[sdram_a[9:0]] = sdram_dq;
                    row_open = 1'b0;
                    chk("dqm_on_write", sdram_dqm, 1'b0);
                end
                if (c == C_RD) begin
                    if (!rd_seen) chk("led_at_first_read", led, 8'h03);
                    rd_seen  = 1'b1;
                    row_open = 1'b0;
                    pv[0] = 1'b1;
                    pd[0] = mem[sdram_a[9:0]] ^ ((corrupt && int'(sdram_a[9:0]) == bad_addr) ? bad_mask : 8'h00);
                    chk("dqm_on_read", sdram_dqm, 1'b0);
                end
                last_cmd = c;
                nop_run  = 0;
                started  = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_cle", sdram_cle, 1'b0);
        chk("rst_cmd", {sdram_cs, sdram_ras, sdram_cas, sdram_we}, 4'b1111);
        chk("rst_dqm", sdram_dqm, 1'b1);
        chk("rst_addr", {sdram_ba, sdram_a}, 15'h0);
        chk("rst_led", led, 8'h00);
        @(negedge clk);
    endtask

    // Reference model of one full test pass: init sequence, then TW write and TW read accesses.
    task automatic start_run(input logic cor, input int addr, input logic [7:0] mask);
        #2;
        exp_q.delete();
        corrupt = cor; bad_addr = addr; bad_mask = mask;
        exp_q.push_back(mk(C_PRE, 13'h0400, 8'h00, 1'b0));
        exp_q.push_back(mk(C_REF, 13'h0000, 8'h00, 1'b0));
        exp_q.push_back(mk(C_REF, 13'h0000, 8'h00, 1'b0));
        exp_q.push_back(mk(C_MRS, MODE_A, 8'h00, 1'b0));
        for (int i = 0; i < TW; i++) begin
            exp_q.push_back(mk(C_ACT, 13'h0000, 8'h00, 1'b0));
            exp_q.push_back(mk(C_WR, 13'h0400 + 13'(i), 8'(i), 1'b1));
        end
        for (int i = 0; i < TW; i++) begin
            exp_q.push_back(mk(C_ACT, 13'h0000, 8'h00, 1'b0));
            exp_q.push_back(mk(C_RD, 13'h0400 + 13'(i), 8'h00, 1'b0));
        end
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input logic [7:0] req_led);
        int n = 0;
        while (led[2] !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
        if (n >= 20000) begin
            checks++; errors++;
            $display("FAIL done_timeout: led=0x%0h after %0d cycles, required led[2]=1", led, n);
        end else begin
            @(negedge clk);
            chk("final_led", led, req_led);
            chk("queue_drained", exp_q.size(), 0);
            repeat (3 * REF_CYC + 20) @(negedge clk);
            chk_range("done_refreshes", done_refs, 2, 100);
            chk("done_led_stable", led, req_led);
        end
    endtask

    initial begin
        int addr, n;
        logic [7:0] mask;
        logic cor;

        do_reset();
        start_run(1'b0, 0, 8'h00);
        wait_done(8'h0F);

        do_reset();
        addr = int'($urandom_range(0, TW - 1));
        mask = 8'($urandom_range(1, 255));
        start_run(1'b1, addr, mask);
        wait_done(8'h17);

        // reset in the middle of the read phase, then a clean re-run
        do_reset();
        start_run(1'b0, 0, 8'h00);
        n = 0;
        while (led[1] !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
        chk("reached_read_phase", led[1], 1'b1);
        repeat ($urandom_range(10, 300)) @(negedge clk);
        do_reset();
        start_run(1'b0, 0, 8'h00);
        wait_done(8'h0F);

        for (int r = 0; r < 2; r++) begin
            do_reset();
            cor  = 1'($urandom_range(0, 1));
            addr = int'($urandom_range(0, TW - 1));
            mask = 8'($urandom_range(1, 255));
            start_run(cor, addr, mask);
            wait_done(cor ? 8'h17 : 8'h0F);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish within 2 ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end
endmodule
